conv_encoder: RTL and testbench

Rate-1/2, constraint-length-3 convolutional encoder that produces the 16-bit codeword consumed by `viterbi_decoder` on its `data` input. It accepts one 8-bit message on a start strobe and encodes it serially, one bit per cycle, MSB first. It then presents the packed codeword with a one-cycle `done_flag`. It closes the encode/decode loop for bench and system use, with an optional error-injection path for exercising the decoder.

---
 rtl/viterbi_pkg.sv | 18 +
 rtl/conv_enc_step.sv | 28 ++
 rtl/conv_encoder.sv | 138 +++++++++++++
 tb/tb_conv_encoder.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/viterbi_pkg.sv
// Shared constants and types for the rate-1/2, K=3 convolutional code used by
// conv_encoder and the viterbi_decoder side (including bench reference models).
package viterbi_pkg;

  localparam int K      = 3;
  localparam int MSG_W  = 8;
  localparam int CODE_W = 2 * MSG_W;

  localparam logic [K-1:0] G0 = 3'b111;
  localparam logic [K-1:0] G1 = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ENC  = 2'd1,
    DONE = 2'd2
  } enc_st_t;

endpackage

// File: rtl/conv_enc_step.sv
// One trellis step of the K=3 encoder: code symbol {c0,c1} and next state for input bit u.
// Pure combinational so a reference model can reuse it as-is.
module conv_enc_step #(
  parameter logic [2:0] G0 = 3'b111,
  parameter logic [2:0] G1 = 3'b101
) (
  input  logic       u,
  input  logic [1:0] s,
  output logic [1:0] sym,
  output logic [1:0] s_next
);

  // Generators packed so that gi=1 selects G0 (c0, MSB of sym) and gi=0 selects G1 (c1).
  localparam logic [5:0] GENS = {G0, G1};

  logic [2:0] taps;
  assign taps = {u, s[1], s[0]};

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_sym
      assign sym[gi] = ^(GENS[gi*3 +: 3] & taps);
    end
  endgenerate

  assign s_next = {u, s[1]};

endmodule

// File: rtl/conv_encoder.sv
// Serial rate-1/2 K=3 convolutional encoder, one message bit per cycle, MSB first.
// Optional error injection on the output codeword: define CONV_ENC_ERR_INJ_EN.
module conv_encoder
  import viterbi_pkg::*;
#(
  parameter int         MSG_W = viterbi_pkg::MSG_W,
  parameter logic [2:0] G0    = viterbi_pkg::G0,
  parameter logic [2:0] G1    = viterbi_pkg::G1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic [MSG_W-1:0]   data_in,
`ifdef CONV_ENC_ERR_INJ_EN
  input  logic [2*MSG_W-1:0] err_mask,
`endif
  output logic               busy,
  output logic [2*MSG_W-1:0] code_out,
  output logic               done_flag
);

  localparam int CW    = 2 * MSG_W;
  localparam int CNT_W = (MSG_W > 1) ? $clog2(MSG_W) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(MSG_W - 1);

  enc_st_t          state_reg, state_next;
  logic [MSG_W-1:0] msg_reg, msg_next;
  logic [CW-1:0]    work_reg, work_next;
  logic [CW-1:0]    code_reg, code_next;
  logic [1:0]       s_reg, s_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic             busy_reg, busy_next;
  logic             done_reg, done_next;
`ifdef CONV_ENC_ERR_INJ_EN
  logic [CW-1:0]    mask_reg, mask_next;
`endif

  logic          u;
  logic [1:0]    sym;
  logic [1:0]    step_s;
  logic [CW-1:0] work_shift;

  assign u = msg_reg[LAST - cnt_reg];

  conv_enc_step #(
    .G0 (G0),
    .G1 (G1)
  ) u_step (
    .u      (u),
    .s      (s_reg),
    .sym    (sym),
    .s_next (step_s)
  );

  // Shifting in from the LSB leaves symbol k at bits [CW-1-2k -: 2] once all MSG_W are in.
  assign work_shift = {work_reg[CW-3:0], sym};

  always_comb begin
    state_next = state_reg;
    msg_next   = msg_reg;
    work_next  = work_reg;
    code_next  = code_reg;
    s_next     = s_reg;
    cnt_next   = cnt_reg;
    busy_next  = 1'b0;
    done_next  = 1'b0;
`ifdef CONV_ENC_ERR_INJ_EN
    mask_next  = mask_reg;
`endif
    case (state_reg)
      IDLE, DONE: begin
        if (en) begin
          msg_next   = data_in;
`ifdef CONV_ENC_ERR_INJ_EN
          mask_next  = err_mask;
`endif
          work_next  = '0;
          s_next     = 2'b00;
          cnt_next   = '0;
          busy_next  = 1'b1;
          state_next = ENC;
        end else if (state_reg == DONE) begin
          state_next = IDLE;
        end
      end
      ENC: begin
        work_next = work_shift;
        s_next    = step_s;
        cnt_next  = cnt_reg + 1'b1;
        busy_next = 1'b1;
        if (cnt_reg == LAST) begin
`ifdef CONV_ENC_ERR_INJ_EN
          code_next = work_shift ^ mask_reg;
`else
          code_next = work_shift;
`endif
          done_next  = 1'b1;
          busy_next  = 1'b0;
          state_next = DONE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= IDLE;
      msg_reg   <= '0;
      work_reg  <= '0;
      code_reg  <= '0;
      s_reg     <= 2'b00;
      cnt_reg   <= '0;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
`ifdef CONV_ENC_ERR_INJ_EN
      mask_reg  <= '0;
`endif
    end else begin
      state_reg <= state_next;
      msg_reg   <= msg_next;
      work_reg  <= work_next;
      code_reg  <= code_next;
      s_reg     <= s_next;
      cnt_reg   <= cnt_next;
      busy_reg  <= busy_next;
      done_reg  <= done_next;
`ifdef CONV_ENC_ERR_INJ_EN
      mask_reg  <= mask_next;
`endif
    end
  end

  assign busy      = busy_reg;
  assign done_flag = done_reg;
  assign code_out  = code_reg;

endmodule

// File: tb/tb_conv_encoder.sv
// Directed scoreboard bench for conv_encoder: latency, busy length, codewords, ignore/restart, reset abort.
module tb_conv_encoder;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        en  = 1'b0;
  logic [7:0]  data_in = 8'h00;
`ifdef CONV_ENC_ERR_INJ_EN
  logic [15:0] err_mask = 16'h0000;
`endif
  logic        busy;
  logic [15:0] code_out;
  logic        done_flag;

  int          checks = 0;
  int          errors = 0;
  int          pulses = 0;
  logic        prev_done = 1'b0;
  logic [15:0] exp_q[$];

  always #5 clk = ~clk;

  conv_encoder dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .data_in   (data_in),
`ifdef CONV_ENC_ERR_INJ_EN
    .err_mask  (err_mask),
`endif
    .busy      (busy),
    .code_out  (code_out),
    .done_flag (done_flag)
  );

  // Independent bit-serial reference: c0 = u^s1^s0, c1 = u^s0, s <= {u,s1}.
  function automatic logic [15:0] model(input logic [7:0] m);
    logic [1:0]  s;
    logic [15:0] c;
    logic        u;
    s = 2'b00;
    c = 16'h0000;
    for (int k = 0; k < 8; k++) begin
      u           = m[7-k];
      c[15-2*k]   = u ^ s[1] ^ s[0];
      c[14-2*k]   = u ^ s[0];
      s           = {u, s[1]};
    end
    return c;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // done_flag must never be high on two consecutive cycles.
  always @(negedge clk) begin
    if (done_flag === 1'b1) begin
      pulses++;
      checks++;
      assert (prev_done !== 1'b1) else begin
        errors++;
        $error("FAIL done_consecutive observed 1 expected 0");
      end
    end
    prev_done = done_flag;
  end

  task automatic start(input logic [7:0] d, input logic [15:0] exp, input bit push);
    @(negedge clk);
    en      = 1'b1;
    data_in = d;
    if (push) exp_q.push_back(exp);
  endtask

  // Waits for done_flag after an accepting edge; optionally holds en or pokes en mid-block.
  task automatic finish_block(input string tag, input bit hold, input logic [7:0] next_d,
                              input int poke_at);
    int          lat;
    int          nbusy;
    bit          unstable;
    bit          got;
    logic [15:0] held;
    logic [15:0] exp;
    lat      = 0;
    nbusy    = 0;
    unstable = 1'b0;
    got      = 1'b0;
    held     = code_out;
    while (lat < 30 && !got) begin
      @(negedge clk);
      lat++;
      if (lat == 1) begin
        if (hold) data_in = next_d;
        else      en = 1'b0;
      end
      if (poke_at != 0 && lat == poke_at) begin
        en      = 1'b1;
        data_in = 8'h55;
      end else if (poke_at != 0 && lat == poke_at + 1) begin
        en = 1'b0;
      end
      if (busy === 1'b1) nbusy++;
      if (done_flag === 1'b1) got = 1'b1;
      else if (code_out !== held) unstable = 1'b1;
    end
    check({tag, "_done_seen"}, 32'(got), 32'd1);
    check({tag, "_latency"}, 32'(lat), 32'd9);
    check({tag, "_busy_cycles"}, 32'(nbusy), 32'd8);
    check({tag, "_code_stable"}, 32'(unstable), 32'd0);
    if (exp_q.size() != 0) begin
      exp = exp_q.pop_front();
      check({tag, "_code_out"}, 32'(code_out), 32'(exp));
    end else begin
      check({tag, "_scoreboard_empty"}, 32'd1, 32'd0);
    end
    $display("block %s: code_out=%h latency=%0d busy=%0d", tag, code_out, lat, nbusy);
  endtask

  initial begin
    logic [7:0] r;
    int         p0;

    repeat (2) @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done_flag), 32'd0);
    check("rst_code", 32'(code_out), 32'd0);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    start(8'h00, 16'h0000, 1'b1); finish_block("zero", 1'b0, 8'h00, 0);
    start(8'h80, 16'hEC00, 1'b1); finish_block("impulse_msb", 1'b0, 8'h00, 0);
    start(8'h01, 16'h0003, 1'b1); finish_block("impulse_lsb", 1'b0, 8'h00, 0);
    start(8'hFF, 16'hDAAA, 1'b1); finish_block("ones", 1'b0, 8'h00, 0);

    start(8'h80, 16'hEC00, 1'b1); finish_block("en_ignored", 1'b0, 8'h00, 3);
    @(negedge clk);

    // en held through DONE: second block accepted on the edge leaving DONE.
    start(8'h80, 16'hEC00, 1'b1);
    exp_q.push_back(16'h0003);
    finish_block("b2b_first", 1'b1, 8'h01, 0);
    finish_block("b2b_second", 1'b0, 8'h00, 0);
    repeat (2) @(negedge clk);

    // Reset during the 4th ENC cycle aborts the block.
    start(8'hFF, 16'h0000, 1'b0);
    @(negedge clk); en = 1'b0;
    repeat (3) @(negedge clk);
    p0  = pulses;
    rst = 1'b0;
    #1;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done_flag), 32'd0);
    check("abort_code", 32'(code_out), 32'd0);
    repeat (12) @(negedge clk);
    check("abort_no_pulse", 32'(pulses), 32'(p0));
    $display("reset abort: busy=%0b done=%0b code_out=%h", busy, done_flag, code_out);
    rst = 1'b1;
    @(negedge clk);
    start(8'h01, 16'h0003, 1'b1); finish_block("after_abort", 1'b0, 8'h00, 0);

    for (int i = 0; i < 4; i++) begin
      r = 8'($urandom_range(0, 255));
      start(r, model(r), 1'b1);
      finish_block("random", 1'b0, 8'h00, 0);
    end

`ifdef CONV_ENC_ERR_INJ_EN
    err_mask = 16'h0001;
    start(8'h80, 16'hEC01, 1'b1); finish_block("err_inj", 1'b0, 8'h00, 0);
    err_mask = 16'h0000;
`endif

    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
